// File: rtl/inst_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_encoder_if
//  Description : Valid/ready handshake bundle for the RISC-V instruction
//                encoder. The field side feeds decoded fields in, and the
//                word side returns the packed 32-bit instruction word.
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_encoder_if;
    // Field-side handshake and payload
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;

    // Word-side handshake and payload
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;

    // Seen from the encoder
    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
               in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );

    // Seen from the surrounding producer/consumer
    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
               in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );
endinterface
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : inst_encoder
//  Description : Packs decoded RISC-V fields into a 32-bit instruction word,
//                scattering the immediate into the I/S/B/U/J layouts.
//                Two-stage valid/ready pipeline, one word per cycle.
//                Optional macro INST_ENC_IMM_CHECK_EN adds an immediate
//                range check that raises out_err (word still emitted).
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    inst_encoder_if.slave         bus,
    output logic [CNT_W-1:0]      inst_count,
    output logic                  busy
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_FLW    = 7'b0000111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_FSW    = 7'b0100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_FP     = 7'b1010011;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    // Stage 1 field registers
    logic        r_s1_valid;
    logic [6:0]  r_opcode;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [2:0]  r_funct3;
    logic [6:0]  r_funct7;
    logic [31:0] r_imm;

    // Stage 2 output registers
    logic             r_out_valid;
    logic [31:0]      r_out_inst;
    logic             r_out_err;
    logic [CNT_W-1:0] r_count;

    logic        w_adv;
    logic        w_accept;
    logic        w_consume;
    logic [31:0] w_inst;
    logic        w_unknown;
    logic        w_err;

    assign w_adv     = !r_out_valid || bus.out_ready;
    assign w_consume = r_out_valid && bus.out_ready;
    assign w_accept  = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = !r_s1_valid || w_adv;
    assign bus.out_valid = r_out_valid;
    assign bus.out_inst  = r_out_inst;
    assign bus.out_err   = r_out_err;
    assign inst_count    = r_count;
    assign busy          = r_s1_valid || r_out_valid;

    // Scatter the stage-1 fields into the layout selected by the opcode
    always_comb begin
        w_inst    = {r_funct7, r_rs2, r_rs1, r_funct3, r_rd, r_opcode};
        w_unknown = 1'b0;
        case (r_opcode)
            c_OP_LOAD, c_OP_IMM, c_OP_JALR, c_OP_FLW:
                w_inst = {r_imm[11:0], r_rs1, r_funct3, r_rd, r_opcode};
            c_OP_STORE, c_OP_FSW:
                w_inst = {r_imm[11:5], r_rs2, r_rs1, r_funct3, r_imm[4:0], r_opcode};
            c_OP_BRANCH:
                w_inst = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_funct3,
                          r_imm[4:1], r_imm[11], r_opcode};
            c_OP_AUIPC, c_OP_LUI:
                w_inst = {r_imm[31:12], r_rd, r_opcode};
            c_OP_JAL:
                w_inst = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_opcode};
            c_OP_REG, c_OP_FP, c_OP_SYSTEM:
                w_inst = {r_funct7, r_rs2, r_rs1, r_funct3, r_rd, r_opcode};
            default:
                w_unknown = 1'b1;
        endcase
    end

`ifdef INST_ENC_IMM_CHECK_EN
    logic w_range_err;

    // Flag immediates that do not survive truncation into their field
    always_comb begin
        w_range_err = 1'b0;
        case (r_opcode)
            c_OP_LOAD, c_OP_IMM, c_OP_JALR, c_OP_FLW, c_OP_STORE, c_OP_FSW:
                w_range_err = !((&r_imm[31:11]) || !(|r_imm[31:11]));
            c_OP_BRANCH:
                w_range_err = !((&r_imm[31:12]) || !(|r_imm[31:12])) || r_imm[0];
            c_OP_JAL:
                w_range_err = !((&r_imm[31:20]) || !(|r_imm[31:20])) || r_imm[0];
            c_OP_AUIPC, c_OP_LUI:
                w_range_err = |r_imm[11:0];
            default:
                w_range_err = 1'b0;
        endcase
    end

    assign w_err = w_unknown || w_range_err;
`else
    assign w_err = w_unknown;
`endif

    // Stage 1: capture fields on accept, drain when stage 2 takes them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
        end else if (w_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 1 payload, no reset needed since it is qualified by r_s1_valid
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_opcode <= bus.in_opcode;
            r_rd     <= bus.in_rd;
            r_rs1    <= bus.in_rs1;
            r_rs2    <= bus.in_rs2;
            r_funct3 <= bus.in_funct3;
            r_funct7 <= bus.in_funct7;
            r_imm    <= bus.in_imm;
        end
    end

    // Stage 2: register the packed word, hold it while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_inst  <= 32'd0;
            r_out_err   <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_inst <= w_inst;
                r_out_err  <= w_err;
            end
        end
    end

    // Count consumed words, wrapping at the counter width
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_consume) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire
